step_scheduler: RTL and testbench
=================================

STEP_SCHEDULER -- requirements
Module: step_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: one clock `clk`, reset `reset`.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, the number of queued move commands (power of 2).
REQ-003 The block SHALL have parameter STEP_PULSE_CYCLES, default 8, the step high time in clk cycles (>=1).
REQ-004 The block SHALL have parameter DIR_SETUP_CYCLES, default 4, the dir-to-first-step setup in clk cycles (>=1).
REQ-005 clk  input  1  system clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 cmd_valid  input  1  move command offered.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready at a clk edge.
REQ-009 cmd_dir  input  1  move direction.
REQ-010 cmd_steps  input  24  unsigned step count.
REQ-011 cmd_period  input  16  unsigned cycles between step rising edges.
REQ-012 abort  input  1  level; flush queue and stop motion.
REQ-013 step  output  1  registered step pulse to the position counter.
REQ-014 dir  output  1  registered direction.
REQ-015 busy  output  1  state != IDLE or queue non-empty.
REQ-016 move_done  output  1  one-cycle pulse when a command completes normally.
REQ-017 aborted  output  1  one-cycle pulse when an abort completes.
REQ-018 queue_level  output  $clog2(FIFO_DEPTH)+1  queued command count.
REQ-019 steps_remaining  output  24  steps left in the active command.

Function
REQ-020 cmd_ready SHALL equal !full && !abort && !aborting.
REQ-021 A push and a pop in the same cycle SHALL leave queue_level unchanged.
REQ-022 The FSM SHALL have states IDLE, LOAD, DIR_SETUP, PULSE_HIGH, PULSE_LOW, ABORT_WAIT.
REQ-023 IDLE: with the queue non-empty and abort low, the FSM SHALL pop the head into active registers and go to LOAD next cycle.
REQ-024 LOAD, steps==0: the FSM SHALL pulse move_done, leave dir unchanged, and return to IDLE.
REQ-025 LOAD, cmd_dir!=dir: the FSM SHALL update dir and go to DIR_SETUP for DIR_SETUP_CYCLES cycles, then to PULSE_HIGH.
REQ-026 LOAD, cmd_dir==dir: the FSM SHALL go directly to PULSE_HIGH.
REQ-027 step SHALL be 1 only in PULSE_HIGH; PULSE_HIGH SHALL last STEP_PULSE_CYCLES cycles.
REQ-028 Effective period SHALL be max(cmd_period, STEP_PULSE_CYCLES+1); PULSE_LOW SHALL last effective period minus STEP_PULSE_CYCLES.
REQ-029 steps_remaining SHALL load cmd_steps in LOAD and decrement on each PULSE_HIGH entry.
REQ-030 After PULSE_LOW with steps_remaining==0, the FSM SHALL pulse move_done and go to IDLE; otherwise it SHALL go to PULSE_HIGH.
REQ-031 dir SHALL never change while step==1 or during PULSE_LOW.
REQ-032 abort in IDLE/LOAD/DIR_SETUP/PULSE_LOW: the queue SHALL flush the next cycle, and the FSM SHALL go to IDLE and pulse aborted.
REQ-033 abort in PULSE_HIGH: the queue SHALL flush and the FSM SHALL go to ABORT_WAIT, completing the high time without a runt pulse, then pulse aborted and go to IDLE.
REQ-034 Abort SHALL NOT produce move_done.
REQ-035 After an abort, steps_remaining SHALL be 0.
REQ-036 abort held high SHALL keep the block in IDLE with the queue empty.
REQ-037 Period and cycle counters SHALL be 16-bit and SHALL NOT wrap; the clamp guarantees a nonzero low time.

Reset
REQ-038 On reset the FSM SHALL enter IDLE and the queue SHALL empty.
REQ-039 On reset, step, dir, busy, move_done, aborted, queue_level and steps_remaining SHALL all be 0, and cmd_ready SHALL be 1 the cycle after reset deasserts.
REQ-040 Reset mid-pulse SHALL drop step the next cycle; no completion pulse SHALL be issued.

Structure
REQ-041 Package ulti_motion_pkg SHALL hold the state enum, STEP_CNT_W=24 and PERIOD_W=16.
REQ-042 The queue SHALL be a sub-module, cmd_fifo: a synchronous FIFO, 41-bit {dir,steps,period} word, with flush input.

Verification
REQ-043 Single move: 1 command dir=0, steps=3, period=20 with dir=0 -> 3 step pulses, 8 cycles high, rising edges 20 cycles apart; one move_done.
REQ-044 Direction change: dir=0, then command dir=1, steps=1 -> dir rises >=4 cycles before step rises; dir stable through the pulse.
REQ-045 Clamp and zero: period=3 -> edges 9 cycles apart; steps=0 -> move_done, no step, dir unchanged.
REQ-046 Queue full: 5 back-to-back pushes while busy -> cmd_ready low after 4 (queue_level=4); the 5th accepted after the first pop; all moves run in order.
REQ-047 Abort in high: abort on the 3rd cycle of PULSE_HIGH with 2 queued -> high lasts 8 cycles, aborted pulses, queue_level=0, no move_done.
REQ-048 Reset mid-move: reset during PULSE_LOW of step 2/5 -> all outputs 0 next cycle, no further steps.

Source files
------------

// File: rtl/ulti_motion_pkg.sv
// rtl/ulti_motion_pkg.sv - shared types and widths for the step scheduler
// Contents: scheduler state enum, step/period counter widths, queued move word.
package ulti_motion_pkg;

   localparam int STEP_CNT_W = 24;
   localparam int PERIOD_W   = 16;
   localparam int CMD_W      = 1 + STEP_CNT_W + PERIOD_W;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DIR_SETUP,
      PULSE_HIGH,
      PULSE_LOW,
      ABORT_WAIT
   } state_e;

   // Queued move word, packed as {dir, steps, period}.
   typedef struct packed {
      logic                  dir;
      logic [STEP_CNT_W-1:0] steps;
      logic [PERIOD_W-1:0]   period;
   } move_cmd_t;

endpackage

// File: rtl/step_scheduler_if.sv
// rtl/step_scheduler_if.sv - move command handshake bundle
// Signals:
//   cmd_valid  - command offered (master -> slave)
//   cmd_ready  - command accepted on cmd_valid && cmd_ready (slave -> master)
//   cmd_dir    - move direction
//   cmd_steps  - unsigned step count
//   cmd_period - unsigned cycles between step rising edges
interface step_scheduler_if;
   import ulti_motion_pkg::*;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_dir;
   logic [STEP_CNT_W-1:0] cmd_steps;
   logic [PERIOD_W-1:0]   cmd_period;

   modport master (
      output cmd_valid,
      output cmd_dir,
      output cmd_steps,
      output cmd_period,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_dir,
      input  cmd_steps,
      input  cmd_period,
      output cmd_ready
   );
endinterface

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous show-ahead command FIFO with flush
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   flush_i      - empty the FIFO at the next edge (wins over push/pop)
//   push_i       - write push_data_i (ignored when full)
//   pop_i        - drop the head entry (ignored when empty)
//   pop_data_o   - current head entry
//   full_o       - DEPTH entries held
//   empty_o      - no entries held
//   level_o      - entry count
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 41
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         pop_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      level_q;
   logic             do_push;
   logic             do_pop;

   assign full_o     = (level_q == LVL_FULL);
   assign empty_o    = (level_q == '0);
   assign level_o    = level_q;
   assign pop_data_o = mem_q[rd_ptr_q];
   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && !empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/step_scheduler.sv
// rtl/step_scheduler.sv - queued stepper-motor move scheduler
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   cmd              - move command handshake (slave side)
//   abort            - level; flush queue and stop motion
//   step             - registered step pulse
//   dir              - registered direction
//   busy             - moving or commands queued
//   move_done        - one-cycle pulse on normal completion
//   aborted          - one-cycle pulse when an abort completes
//   queue_level      - queued command count
//   steps_remaining  - steps left in the active command
module step_scheduler
   import ulti_motion_pkg::*;
#(
   parameter int FIFO_DEPTH        = 4,
   parameter int STEP_PULSE_CYCLES = 8,
   parameter int DIR_SETUP_CYCLES  = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   step_scheduler_if.slave             cmd,
   input  logic                        abort,
   output logic                        step,
   output logic                        dir,
   output logic                        busy,
   output logic                        move_done,
   output logic                        aborted,
   output logic [$clog2(FIFO_DEPTH):0] queue_level,
   output logic [STEP_CNT_W-1:0]       steps_remaining
);
   localparam logic [PERIOD_W-1:0] HIGH_CYC   = PERIOD_W'(STEP_PULSE_CYCLES);
   localparam logic [PERIOD_W-1:0] HIGH_LOAD  = PERIOD_W'(STEP_PULSE_CYCLES - 1);
   localparam logic [PERIOD_W-1:0] SETUP_LOAD = PERIOD_W'(DIR_SETUP_CYCLES - 1);

   state_e                state_q, state_d;
   logic [PERIOD_W-1:0]   cnt_q, cnt_d;
   logic [STEP_CNT_W-1:0] steps_q, steps_d;
   logic                  dir_q, dir_d;
   logic                  act_dir_q, act_dir_d;
   logic [PERIOD_W-1:0]   act_period_q, act_period_d;
   logic                  step_q, step_d;
   logic                  move_done_q, move_done_d;
   logic                  aborted_q, aborted_d;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_pop;
   logic [CMD_W-1:0]      fifo_head;
   move_cmd_t             head;
   logic [PERIOD_W-1:0]   low_load;
   logic                  go_high;
   logic                  go_abort;

   assign cmd.cmd_ready = !fifo_full && !abort && (state_q != ABORT_WAIT);
   assign head          = move_cmd_t'(fifo_head);

   // Low time is effective period minus high time; a short period is
   // clamped so at least one low cycle always separates pulses.
   assign low_load = (act_period_q > HIGH_CYC) ? (act_period_q - HIGH_CYC - 1'b1) : '0;

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_cmd_fifo (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (abort),
      .push_i      (cmd.cmd_valid && cmd.cmd_ready),
      .push_data_i ({cmd.cmd_dir, cmd.cmd_steps, cmd.cmd_period}),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (queue_level)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      steps_d      = steps_q;
      dir_d        = dir_q;
      act_dir_d    = act_dir_q;
      act_period_d = act_period_q;
      move_done_d  = 1'b0;
      aborted_d    = 1'b0;
      fifo_pop     = 1'b0;
      go_high      = 1'b0;
      go_abort     = 1'b0;

      case (state_q)
         IDLE: begin
            if (abort) begin
               // Only report an abort when there was queued work to discard.
               aborted_d = !fifo_empty;
            end else if (!fifo_empty) begin
               fifo_pop     = 1'b1;
               act_dir_d    = head.dir;
               act_period_d = head.period;
               steps_d      = head.steps;
               state_d      = LOAD;
            end
         end
         LOAD: begin
            if (abort) begin
               go_abort = 1'b1;
            end else if (steps_q == '0) begin
               move_done_d = 1'b1;
               state_d     = IDLE;
            end else if (act_dir_q != dir_q) begin
               dir_d   = act_dir_q;
               cnt_d   = SETUP_LOAD;
               state_d = DIR_SETUP;
            end else begin
               go_high = 1'b1;
            end
         end
         DIR_SETUP: begin
            if (abort)             go_abort = 1'b1;
            else if (cnt_q == '0)  go_high  = 1'b1;
            else                   cnt_d    = cnt_q - 1'b1;
         end
         PULSE_HIGH: begin
            if (abort) begin
               // Finish the high time rather than cutting the pulse short.
               if (cnt_q == '0) go_abort = 1'b1;
               else begin
                  cnt_d   = cnt_q - 1'b1;
                  state_d = ABORT_WAIT;
               end
            end else if (cnt_q == '0) begin
               cnt_d   = low_load;
               state_d = PULSE_LOW;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         PULSE_LOW: begin
            if (abort) begin
               go_abort = 1'b1;
            end else if (cnt_q == '0) begin
               if (steps_q == '0) begin
                  move_done_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  go_high = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ABORT_WAIT: begin
            if (cnt_q == '0) go_abort = 1'b1;
            else             cnt_d    = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (go_high) begin
         state_d = PULSE_HIGH;
         cnt_d   = HIGH_LOAD;
         steps_d = steps_q - 1'b1;
      end
      if (go_abort) begin
         state_d   = IDLE;
         cnt_d     = '0;
         steps_d   = '0;
         aborted_d = 1'b1;
      end
   end

   assign step_d = (state_d == PULSE_HIGH) || (state_d == ABORT_WAIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         steps_q      <= '0;
         dir_q        <= 1'b0;
         act_dir_q    <= 1'b0;
         act_period_q <= '0;
         step_q       <= 1'b0;
         move_done_q  <= 1'b0;
         aborted_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         steps_q      <= steps_d;
         dir_q        <= dir_d;
         act_dir_q    <= act_dir_d;
         act_period_q <= act_period_d;
         step_q       <= step_d;
         move_done_q  <= move_done_d;
         aborted_q    <= aborted_d;
      end
   end

   assign step            = step_q;
   assign dir             = dir_q;
   assign busy            = (state_q != IDLE) || !fifo_empty;
   assign move_done       = move_done_q;
   assign aborted         = aborted_q;
   assign steps_remaining = steps_q;

endmodule

// File: tb/tb_step_scheduler.sv
// tb/tb_step_scheduler.sv - self-checking bench for step_scheduler
module tb_step_scheduler;
   import ulti_motion_pkg::*;

   localparam int DEPTH = 4;
   localparam int SPC   = 8;
   localparam int DSC   = 4;
   localparam int NV    = 7;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic abort = 1'b0;
   logic step, dir, busy, move_done, aborted;
   logic [$clog2(DEPTH):0]  queue_level;
   logic [STEP_CNT_W-1:0]   steps_remaining;

   step_scheduler_if cmd_if();

   step_scheduler #(
      .FIFO_DEPTH        (DEPTH),
      .STEP_PULSE_CYCLES (SPC),
      .DIR_SETUP_CYCLES  (DSC)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .cmd             (cmd_if),
      .abort           (abort),
      .step            (step),
      .dir             (dir),
      .busy            (busy),
      .move_done       (move_done),
      .aborted         (aborted),
      .queue_level     (queue_level),
      .steps_remaining (steps_remaining)
   );

   always #5 clk = ~clk;

   typedef struct { logic dir; int steps; int period; int exp_sp; } vec_t;
   typedef struct { int steps; int exp_sp; logic exp_dir; } exp_t;
   typedef struct {
      int rises; int spacing; bit spacing_ok; bit highs_ok; bit dir_stable; int setup; logic dir_val;
   } res_t;

   exp_t exp_q[$];
   res_t res_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   logic model_dir = 1'b0;

   // Monitor state
   int   cyc = 0;
   logic prev_step = 1'b0;
   logic prev_dir = 1'b0;
   int   rises, spacing, setup, last_rise, high_len, last_high;
   bit   spacing_ok, highs_ok, dir_stable;
   int   dir_change_cyc = -1000;
   int   done_cnt = 0;
   int   abort_cnt = 0;
   int   total_rises = 0;

   task automatic mon_clear();
      rises = 0; spacing = 0; spacing_ok = 1'b1; highs_ok = 1'b1; dir_stable = 1'b1; setup = 1000;
   endtask

   initial begin
      mon_clear();
      high_len = 0; last_high = 0; last_rise = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            mon_clear();
            prev_step = 1'b0; prev_dir = 1'b0; high_len = 0;
         end else begin
            if (dir !== prev_dir) begin
               dir_change_cyc = cyc;
               if (rises > 0 || step) dir_stable = 1'b0;
            end
            if (step && !prev_step) begin
               total_rises++;
               if (rises == 0) setup = cyc - dir_change_cyc;
               else begin
                  if (rises >= 2 && (cyc - last_rise) != spacing) spacing_ok = 1'b0;
                  spacing = cyc - last_rise;
               end
               last_rise = cyc;
               rises++;
               high_len = 0;
            end
            if (step) high_len++;
            if (!step && prev_step) begin
               last_high = high_len;
               if (high_len != SPC) highs_ok = 1'b0;
            end
            if (move_done) begin
               done_cnt++;
               res_q.push_back('{rises, spacing, spacing_ok, highs_ok, dir_stable, setup, dir});
               mon_clear();
            end
            if (aborted) begin
               abort_cnt++;
               mon_clear();
            end
            prev_step = step;
            prev_dir  = dir;
         end
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic push_cmd(input logic d, input int s, input int p, input int sp, output bit ok);
      logic r;
      exp_t e;
      ok = 1'b0;
      cmd_if.cmd_dir    = d;
      cmd_if.cmd_steps  = STEP_CNT_W'(s);
      cmd_if.cmd_period = PERIOD_W'(p);
      cmd_if.cmd_valid  = 1'b1;
      for (int i = 0; i < 400; i++) begin
         #1;
         r = cmd_if.cmd_ready;
         @(posedge clk);
         if (r) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      if (ok) begin
         e.steps   = s;
         e.exp_sp  = sp;
         e.exp_dir = (s == 0) ? model_dir : d;
         model_dir = e.exp_dir;
         exp_q.push_back(e);
      end else begin
         check("push_timeout", 0, 1);
      end
   endtask

   task automatic check_move(input string tag);
      res_t r;
      exp_t e;
      for (int i = 0; i < 2000 && res_q.size() == 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (res_q.size() == 0 || exp_q.size() == 0) begin
         check({tag, "_done_timeout"}, 0, 1);
         return;
      end
      r = res_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_rises"}, r.rises, e.steps);
      check({tag, "_dir"}, r.dir_val, e.exp_dir);
      check({tag, "_high_len"}, r.highs_ok, 1);
      check({tag, "_dir_stable"}, r.dir_stable, 1);
      check({tag, "_spacing_uniform"}, r.spacing_ok, 1);
      if (e.steps >= 2) check({tag, "_spacing"}, r.spacing, e.exp_sp);
      if (e.steps > 0)  check({tag, "_dir_setup_ge4"}, (r.setup >= DSC), 1);
   endtask

   vec_t vecs[NV];
   bit   ok;
   int   d0, a0, r0;

   initial begin
      cmd_if.cmd_valid  = 1'b0;
      cmd_if.cmd_dir    = 1'b0;
      cmd_if.cmd_steps  = '0;
      cmd_if.cmd_period = '0;

      vecs[0] = '{1'b0, 3, 20, 20};
      vecs[1] = '{1'b0, 3, 3, 9};
      vecs[2] = '{1'b0, 0, 20, 0};
      vecs[3] = '{1'b1, 1, 10, 0};
      vecs[4] = '{1'b1, 4, 9, 9};
      vecs[5] = '{1'b0, 0, 50, 0};
      vecs[6] = '{1'b0, 2, 16, 16};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_step", step, 0);
      check("rst_dir", dir, 0);
      check("rst_busy", busy, 0);
      check("rst_move_done", move_done, 0);
      check("rst_aborted", aborted, 0);
      check("rst_queue_level", queue_level, 0);
      check("rst_steps_remaining", steps_remaining, 0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_cmd_ready", cmd_if.cmd_ready, 1);

      // Single moves from the vector table
      for (int i = 0; i < NV; i++) begin
         push_cmd(vecs[i].dir, vecs[i].steps, vecs[i].period, vecs[i].exp_sp, ok);
         check_move($sformatf("vec%0d", i));
         check($sformatf("vec%0d_idle_busy", i), busy, 0);
         check($sformatf("vec%0d_idle_steps_rem", i), steps_remaining, 0);
      end

      // Queue full: one running move, then five back-to-back pushes
      @(negedge clk);
      push_cmd(model_dir, 2, 20, 20, ok);
      for (int i = 0; i < 100 && !step; i++) @(negedge clk);
      push_cmd(1'b1, 1, 9, 0, ok);
      push_cmd(1'b1, 2, 9, 9, ok);
      push_cmd(1'b0, 3, 9, 9, ok);
      push_cmd(1'b0, 1, 9, 0, ok);
      #1;
      check("q_level_full", queue_level, 4);
      check("q_ready_low", cmd_if.cmd_ready, 0);
      check("q_still_first_move", done_cnt, NV);
      push_cmd(1'b1, 2, 12, 12, ok);
      check("q_fifth_accepted", ok, 1);
      for (int i = 0; i < 6; i++) check_move($sformatf("q%0d", i));

      // Abort on the third cycle of a high pulse with two commands queued
      d0 = done_cnt;
      a0 = abort_cnt;
      @(negedge clk);
      push_cmd(model_dir, 5, 20, 20, ok);
      push_cmd(model_dir, 2, 20, 20, ok);
      push_cmd(model_dir, 2, 20, 20, ok);
      for (int i = 0; i < 100 && !(step && high_len == 3); i++) begin
         @(negedge clk);
         #1;
      end
      check("ab_high_cycle3", high_len, 3);
      check("ab_level_before", queue_level, 2);
      abort = 1'b1;
      @(negedge clk);
      #1;
      abort = 1'b0;
      check("ab_level_flushed", queue_level, 0);
      check("ab_ready_low_wait", cmd_if.cmd_ready, 0);
      check("ab_step_held", step, 1);
      for (int i = 0; i < 50 && abort_cnt == a0; i++) begin
         @(negedge clk);
         #1;
      end
      check("ab_aborted_pulse", abort_cnt, a0 + 1);
      check("ab_high_len", last_high, SPC);
      check("ab_steps_rem", steps_remaining, 0);
      check("ab_busy", busy, 0);
      repeat (60) @(negedge clk);
      #1;
      check("ab_no_move_done", done_cnt, d0);
      check("ab_no_result", res_q.size(), 0);
      exp_q.delete();

      // Abort held high keeps the block idle with an empty queue
      abort = 1'b1;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_steps = 24'd3;
      repeat (3) @(negedge clk);
      #1;
      check("hold_ready", cmd_if.cmd_ready, 0);
      check("hold_level", queue_level, 0);
      check("hold_busy", busy, 0);
      cmd_if.cmd_valid = 1'b0;
      abort = 1'b0;
      @(negedge clk);

      // Reset during the low time of step 2 of 5
      d0 = done_cnt;
      a0 = abort_cnt;
      r0 = total_rises;
      push_cmd(1'b1, 5, 20, 20, ok);
      for (int i = 0; i < 200 && total_rises < r0 + 2; i++) begin
         @(negedge clk);
         #1;
      end
      for (int i = 0; i < 50 && step; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      #1;
      check("rm_second_rise", total_rises, r0 + 2);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check("rm_step", step, 0);
      check("rm_dir", dir, 0);
      check("rm_busy", busy, 0);
      check("rm_move_done", move_done, 0);
      check("rm_aborted", aborted, 0);
      check("rm_queue_level", queue_level, 0);
      check("rm_steps_rem", steps_remaining, 0);
      reset = 1'b0;
      model_dir = 1'b0;
      exp_q.delete();
      r0 = total_rises;
      @(negedge clk);
      #1;
      check("rm_ready_after", cmd_if.cmd_ready, 1);
      repeat (60) @(negedge clk);
      #1;
      check("rm_no_more_steps", total_rises, r0);
      check("rm_no_done", done_cnt, d0);
      check("rm_no_aborted", abort_cnt, a0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
